// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky request queuing, valid/ready output
// and overflow detection; fixed-priority (MODE 0) or round-robin (MODE 1).
module prio_encoder_q #(
  parameter int unsigned N    = 9,
  parameter int unsigned W    = 4,
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         clr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         overflow
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  pending_q, pending_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_code_q, out_code_d;
  logic          overflow_q, overflow_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [N-1:0]  cand_c;
  logic          load_c;
  logic [IW-1:0] base_c;
  logic [IW-1:0] sel_c;
  logic          hit_c;
  int unsigned   best_c;
  int unsigned   base32_c;
  int unsigned   dist_c;

  assign cand_c = pending_q | req;
  assign load_c = ~out_valid_q | out_ready;

  // Fixed priority is round-robin with the pointer pinned at 0 (search N-1 down to 0)
  assign base_c   = (MODE == 1) ? ptr_q : '0;
  assign base32_c = 32'(base_c);

  // Pick the candidate with the smallest descending-wrap distance from the pointer;
  // the pointer line itself has distance N, so it is considered last.
  always_comb begin
    sel_c  = '0;
    hit_c  = 1'b0;
    best_c = N + 1;
    dist_c = 0;
    for (int unsigned i = 0; i < N; i++) begin
      dist_c = (base32_c > i) ? (base32_c - i) : (base32_c + N - i);
      if (cand_c[i] && (dist_c < best_c)) begin
        best_c = dist_c;
        sel_c  = IW'(i);
        hit_c  = 1'b1;
      end
    end
  end

  always_comb begin
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_code_d  = out_code_q;
    overflow_d  = overflow_q;
    ptr_d       = ptr_q;
    if (clr) begin
      pending_d   = '0;
      out_valid_d = 1'b0;
      out_code_d  = '0;
      overflow_d  = 1'b0;
      ptr_d       = '0;
    end else begin
      overflow_d = overflow_q | (|(req & pending_q));
      pending_d  = cand_c;
      if (load_c) begin
        if (hit_c) begin
          out_valid_d = 1'b1;
          out_code_d  = W'(sel_c) + W'(1);
          pending_d   = cand_c & ~(N'(1) << sel_c);
          ptr_d       = sel_c;
        end else begin
          out_valid_d = 1'b0;
          out_code_d  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_code_q  <= '0;
      overflow_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_code_q  <= out_code_d;
      overflow_q  <= overflow_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_code  = out_code_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q: one fixed-priority and one round-robin
// instance share stimulus; each scenario task checks its own expectations.
module tb_prio_encoder_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       out_ready;
  logic [8:0] req;

  logic       fp_valid, rr_valid;
  logic [3:0] fp_code, rr_code;
  logic [8:0] fp_pending, rr_pending;
  logic       fp_ovf, rr_ovf;

  int checks   = 0;
  int failures = 0;

  prio_encoder_q #(.N(9), .W(4), .MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
    .out_valid(fp_valid), .out_ready(out_ready), .out_code(fp_code),
    .pending(fp_pending), .overflow(fp_ovf)
  );

  prio_encoder_q #(.N(9), .W(4), .MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .clr(clr),
    .out_valid(rr_valid), .out_ready(out_ready), .out_code(rr_code),
    .pending(rr_pending), .overflow(rr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; out_ready = 1'b0; req = '0;
    #12;
    checks++;
    if ({fp_valid, fp_code, fp_pending, fp_ovf} !== 15'd0) begin
      $display("FAIL reset_fp got=%h want=0", {fp_valid, fp_code, fp_pending, fp_ovf});
      failures++;
    end
    checks++;
    if ({rr_valid, rr_code, rr_pending, rr_ovf} !== 15'd0) begin
      $display("FAIL reset_rr got=%h want=0", {rr_valid, rr_code, rr_pending, rr_ovf});
      failures++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fixed_priority();
    logic [3:0] exp_code [4] = '{4'd9, 4'd8, 4'd6, 4'd3};
    out_ready = 1'b1;
    req = 9'h1A4;
    step();
    req = '0;
    checks++;
    if (fp_pending !== 9'h0A4) begin
      $display("FAIL fp_first_pending got=%h want=0a4", fp_pending);
      failures++;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fp_valid !== 1'b1 || fp_code !== exp_code[i]) begin
        $display("FAIL fp_seq[%0d] got valid=%b code=%0d want valid=1 code=%0d",
                 i, fp_valid, fp_code, exp_code[i]);
        failures++;
      end
      step();
    end
    checks++;
    if (fp_valid !== 1'b0 || fp_code !== 4'd0 || fp_pending !== 9'd0 || fp_ovf !== 1'b0) begin
      $display("FAIL fp_drain got valid=%b code=%0d pend=%h ovf=%b want 0/0/0/0",
               fp_valid, fp_code, fp_pending, fp_ovf);
      failures++;
    end
  endtask

  task automatic test_round_robin();
    clr = 1'b1; out_ready = 1'b1; req = '0;
    step();
    clr = 1'b0;
    req = 9'h1FF;
    step();
    req = '0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (rr_valid !== 1'b1 || rr_code !== 4'(9 - i)) begin
        $display("FAIL rr_all[%0d] got valid=%b code=%0d want valid=1 code=%0d",
                 i, rr_valid, rr_code, 9 - i);
        failures++;
      end
      step();
    end
    checks++;
    if (rr_valid !== 1'b0 || rr_code !== 4'd0) begin
      $display("FAIL rr_drain got valid=%b code=%0d want 0/0", rr_valid, rr_code);
      failures++;
    end
    // pointer sits at line 0: next search starts at line 8
    req = 9'h101;
    step();
    req = '0;
    checks++;
    if (rr_code !== 4'd9) begin
      $display("FAIL rr_wrap_a got=%0d want=9", rr_code);
      failures++;
    end
    step();
    checks++;
    if (rr_code !== 4'd1) begin
      $display("FAIL rr_wrap_b got=%0d want=1", rr_code);
      failures++;
    end
    step();
    req = 9'h002;
    step();
    req = 9'h101;
    checks++;
    if (rr_code !== 4'd2) begin
      $display("FAIL rr_line1 got=%0d want=2", rr_code);
      failures++;
    end
    // pointer now at line 1: line 0 is searched before line 8
    step();
    req = '0;
    checks++;
    if (rr_code !== 4'd1 || fp_code !== 4'd9) begin
      $display("FAIL rr_rotate_a got rr=%0d fp=%0d want rr=1 fp=9", rr_code, fp_code);
      failures++;
    end
    step();
    checks++;
    if (rr_code !== 4'd9 || fp_code !== 4'd1) begin
      $display("FAIL rr_rotate_b got rr=%0d fp=%0d want rr=9 fp=1", rr_code, fp_code);
      failures++;
    end
    step();
  endtask

  task automatic test_back_pressure();
    clr = 1'b1; out_ready = 1'b0; req = '0;
    step();
    clr = 1'b0;
    req = 9'h010;
    step();
    req = 9'h080;
    checks++;
    if (fp_valid !== 1'b1 || fp_code !== 4'd5 || fp_pending !== 9'd0) begin
      $display("FAIL bp_first got valid=%b code=%0d pend=%h want 1/5/000",
               fp_valid, fp_code, fp_pending);
      failures++;
    end
    step();
    req = '0;
    checks++;
    if (fp_valid !== 1'b1 || fp_code !== 4'd5 || fp_pending !== 9'h080) begin
      $display("FAIL bp_stall got valid=%b code=%0d pend=%h want 1/5/080",
               fp_valid, fp_code, fp_pending);
      failures++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (fp_valid !== 1'b1 || fp_code !== 4'd8 || fp_pending !== 9'd0) begin
      $display("FAIL bp_next got valid=%b code=%0d pend=%h want 1/8/000",
               fp_valid, fp_code, fp_pending);
      failures++;
    end
    step();
    checks++;
    if (fp_valid !== 1'b1 || fp_code !== 4'd8) begin
      $display("FAIL bp_hold got valid=%b code=%0d want 1/8", fp_valid, fp_code);
      failures++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (fp_valid !== 1'b0 || fp_code !== 4'd0) begin
      $display("FAIL bp_drain got valid=%b code=%0d want 0/0", fp_valid, fp_code);
      failures++;
    end
  endtask

  task automatic test_overflow();
    int grants = 0;
    clr = 1'b1; out_ready = 1'b0; req = '0;
    step();
    clr = 1'b0;
    req = 9'h004;
    step();
    checks++;
    if (fp_code !== 4'd3 || fp_pending !== 9'd0 || fp_ovf !== 1'b0) begin
      $display("FAIL ovf_first got code=%0d pend=%h ovf=%b want 3/000/0",
               fp_code, fp_pending, fp_ovf);
      failures++;
    end
    step();
    checks++;
    if (fp_code !== 4'd3 || fp_pending !== 9'h004 || fp_ovf !== 1'b0) begin
      $display("FAIL ovf_second got code=%0d pend=%h ovf=%b want 3/004/0",
               fp_code, fp_pending, fp_ovf);
      failures++;
    end
    step();
    req = '0;
    checks++;
    if (fp_code !== 4'd3 || fp_pending !== 9'h004 || fp_ovf !== 1'b1) begin
      $display("FAIL ovf_third got code=%0d pend=%h ovf=%b want 3/004/1",
               fp_code, fp_pending, fp_ovf);
      failures++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (fp_valid && out_ready && fp_code == 4'd3) grants++;
      step();
    end
    out_ready = 1'b0;
    checks++;
    if (grants != 2 || fp_ovf !== 1'b1 || fp_pending !== 9'd0) begin
      $display("FAIL ovf_grants got grants=%0d ovf=%b pend=%h want 2/1/000",
               grants, fp_ovf, fp_pending);
      failures++;
    end
  endtask

  task automatic test_clr();
    bit seen = 1'b0;
    out_ready = 1'b0;
    req = 9'h001;
    step();
    req = '0;
    checks++;
    if (fp_valid !== 1'b1 || fp_ovf !== 1'b1) begin
      $display("FAIL clr_pre got valid=%b ovf=%b want 1/1", fp_valid, fp_ovf);
      failures++;
    end
    clr = 1'b1;
    req = 9'h0FF;
    step();
    clr = 1'b0;
    req = '0;
    checks++;
    if ({fp_valid, fp_code, fp_pending, fp_ovf} !== 15'd0 || rr_valid !== 1'b0) begin
      $display("FAIL clr_state got valid=%b code=%0d pend=%h ovf=%b want all 0",
               fp_valid, fp_code, fp_pending, fp_ovf);
      failures++;
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (fp_valid || rr_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      $display("FAIL clr_no_grant got grant_seen=%b want 0", seen);
      failures++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req = 9'h100;
    step();
    req = '0;
    checks++;
    if (fp_valid !== 1'b1 || fp_code !== 4'd9) begin
      $display("FAIL arst_pre got valid=%b code=%0d want 1/9", fp_valid, fp_code);
      failures++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fp_valid !== 1'b0 || fp_code !== 4'd0 || rr_valid !== 1'b0 || rr_code !== 4'd0) begin
      $display("FAIL arst_drop got fp=%b/%0d rr=%b/%0d want 0/0 0/0",
               fp_valid, fp_code, rr_valid, rr_code);
      failures++;
    end
    #2;
    rst_n = 1'b1;
    step();
    checks++;
    if (fp_valid !== 1'b0 || fp_pending !== 9'd0) begin
      $display("FAIL arst_after got valid=%b pend=%h want 0/000", fp_valid, fp_pending);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_back_pressure();
    test_overflow();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
